cu_data_read_engine_multi_channel: RTL and testbench
====================================================

# cu_data_read_engine_multi_channel

Parametrised multi-channel read engine for a compute unit. It takes up to NUM_CHANNELS independent array-read jobs (base address plus element count), splits each into cacheline read commands, and issues them round-robin under a per-channel outstanding-command limit. It tracks completions per channel and reports per-channel done and an aggregate element count. It sits between WED/job setup and the read command buffer, with back-pressure taken from the command and data buffer almost-full flags.

## Interface
- NUM_CHANNELS, 4: number of independent read channels (≥1); CH_W = max(1,$clog2(NUM_CHANNELS)).
- ADDR_W, 64: address width.
- SIZE_W, 32: element-count width (job size, counters).
- ELEMS_PER_CL, 32: elements per cacheline command; RS_W = $clog2(ELEMS_PER_CL+1).
- CL_BYTES, 128: address stride per command.
- MAX_OUTSTANDING, 8: per-channel issued-but-unanswered limit; OS_W = $clog2(MAX_OUTSTANDING+1).
- clock  in  1  clock; all state on posedge.
- rstn  in  1  asynchronous, active-low reset.
- enabled_in  in  1  engine enable, registered internally (enabled).
- cfg_valid_in  in  1  load a job into channel cfg_channel_in.
- cfg_channel_in  in  CH_W  target channel.
- cfg_address_in  in  ADDR_W  job base address.
- cfg_size_in  in  SIZE_W  job size in elements.
- cfg_shared_in  in  1  1 = READ_CL_S, 0 = READ_CL_NA for this job.
- cfg_ready_out  out  1  combinational: selected channel is IDLE or DONE.
- cmd_alfull_in  in  1  read command buffer almost full.
- data_alfull_in  in  1  read data buffer almost full.
- cmd_valid_out  out  1  command valid, one cycle per command.
- cmd_channel_out  out  CH_W  issuing channel.
- cmd_address_out  out  ADDR_W  cacheline address.
- cmd_real_size_out  out  RS_W  elements carried (1..ELEMS_PER_CL).
- cmd_shared_out  out  1  command type select.
- rsp_valid_in  in  1  read response.
- rsp_channel_in  in  CH_W  responding channel.
- rsp_real_size_in  in  RS_W  elements completed.
- channel_done_out  out  NUM_CHANNELS  per-channel job complete.
- job_counter_done_out  out  SIZE_W  total elements completed, all channels.
- rsp_error_out  out  1  sticky: response to a channel with zero outstanding.

## Operation
- Per-channel FSM: IDLE → ISSUE → DRAIN → DONE. A cfg in IDLE or DONE loads base, size and shared, and clears the remaining, issued, outstanding and completed counters. The channel goes to ISSUE, or straight to DONE if size = 0. cfg to a busy channel is ignored.
- ISSUE: the channel is eligible when remaining > 0 and outstanding < MAX_OUTSTANDING.
- Global issue gate: enabled & ~cmd_alfull_in & ~data_alfull_in.
- Round-robin arbiter grants at most one eligible channel per cycle. The pointer moves to granted+1 mod NUM_CHANNELS.
- On grant:
  - real_size = min(remaining, ELEMS_PER_CL); remaining -= real_size.
  - address = base + issued·CL_BYTES (mod 2^ADDR_W); issued++; outstanding++.
  - When remaining reaches 0, the channel moves to DRAIN.
- Responses are latched one cycle. If the channel has outstanding = 0: ignore, set rsp_error_out. Otherwise outstanding-- and completed += real_size, and job_counter_done_out += real_size (mod 2^SIZE_W).
- Responses are counted regardless of enabled.
- Grant and response to the same channel in the same cycle: outstanding is unchanged net, and both counters update.
- DRAIN → DONE when outstanding = 0 and completed ≥ size. DONE holds channel_done_out high until that channel is reloaded.
- enabled low stalls new grants only; state and counters are held.

## Timing
- Reset values: all outputs 0; all channels IDLE; arbiter pointer 0; all counters 0; rsp_error_out cleared only by reset.
- Reset mid-operation: everything is cleared asynchronously. In-flight responses arriving after reset count as errors only if rsp_valid_in is asserted after rstn deasserts.
- cfg sampled at edge k → channel in ISSUE after k. First grant at edge k+1 → cmd_valid_out high after k+1, provided enabled was already high.
- size = 0: channel_done_out high after edge k.
- Command outputs are registered; cmd_valid_out falls the cycle after the last grant.
- Almost-full flags are sampled at the grant edge; at most one command follows their assertion.
- Response at edge r: counters updated after r+1; channel_done_out high after r+2 if it was the last response.
- enabled_in → enabled adds one cycle before grants start or stop.

## Test plan
- One channel: base 0x1000, size 70, shared 1, responses immediate → commands (0x1000,32), (0x1080,32), (0x1100,6), all cmd_shared_out=1; channel_done_out[0]=1 two cycles after the third response; job_counter_done_out=70.
- Four channels each size 64, free-running → grant order 0,1,2,3,0,1,2,3; each channel gets 2 commands; all channel_done_out bits high; total = 256.
- MAX_OUTSTANDING=2, size 128, responses withheld → exactly 2 commands, then stall. One response → exactly one more command; DONE only after all 4 responses.
- Toggle cmd_alfull_in high for 5 cycles during ISSUE → no grant at those edges, at most one cmd_valid_out after assertion; addresses remain contiguous with no gaps or duplicates.
- Spurious rsp on idle channel 2 → rsp_error_out=1 and stays 1; job_counter_done_out unchanged. Size-0 cfg → done after one edge with no commands.
- Assert rstn low mid-job → all outputs 0 immediately. Reload after release → job reissues from base.

Source files
------------

// File: rtl/cu_data_read_engine_multi_channel.sv
// ---------------------------------------------------------------------------
// cu_data_read_engine_multi_channel
//
// Multi-channel array read engine. Each channel takes a job (base address,
// element count, shared/non-allocating type), splits it into cacheline read
// commands of up to ELEMS_PER_CL elements and issues them through a
// round-robin arbiter, at most MAX_OUTSTANDING unanswered commands per
// channel. Responses are latched for one cycle, then retire outstanding
// commands and add their element counts to per-channel and aggregate totals.
//
// Ports
//   clock, rstn            clock, asynchronous active-low reset
//   enabled_in             engine enable (registered before use)
//   cfg_*_in               job load: channel, base address, size, shared
//   cfg_ready_out          selected channel can accept a job (IDLE/DONE)
//   cmd_alfull_in          command buffer almost full (blocks grants)
//   data_alfull_in         data buffer almost full (blocks grants)
//   cmd_*_out              registered command: valid, channel, address,
//                          element count, shared type
//   rsp_*_in               read response: valid, channel, element count
//   channel_done_out       per-channel job complete
//   job_counter_done_out   elements completed across all channels
//   rsp_error_out          sticky: response to a channel with none pending
// ---------------------------------------------------------------------------
module cu_data_read_engine_multi_channel #(
   parameter int  NUM_CHANNELS    = 4,
   parameter int  ADDR_W          = 64,
   parameter int  SIZE_W          = 32,
   parameter int  ELEMS_PER_CL    = 32,
   parameter int  CL_BYTES        = 128,
   parameter int  MAX_OUTSTANDING = 8,
   localparam int CH_W            = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int RS_W            = $clog2(ELEMS_PER_CL + 1),
   localparam int OS_W            = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                    clock,
   input  logic                    rstn,
   input  logic                    enabled_in,
   input  logic                    cfg_valid_in,
   input  logic [CH_W-1:0]         cfg_channel_in,
   input  logic [ADDR_W-1:0]       cfg_address_in,
   input  logic [SIZE_W-1:0]       cfg_size_in,
   input  logic                    cfg_shared_in,
   output logic                    cfg_ready_out,
   input  logic                    cmd_alfull_in,
   input  logic                    data_alfull_in,
   output logic                    cmd_valid_out,
   output logic [CH_W-1:0]         cmd_channel_out,
   output logic [ADDR_W-1:0]       cmd_address_out,
   output logic [RS_W-1:0]         cmd_real_size_out,
   output logic                    cmd_shared_out,
   input  logic                    rsp_valid_in,
   input  logic [CH_W-1:0]         rsp_channel_in,
   input  logic [RS_W-1:0]         rsp_real_size_in,
   output logic [NUM_CHANNELS-1:0] channel_done_out,
   output logic [SIZE_W-1:0]       job_counter_done_out,
   output logic                    rsp_error_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } ch_state_e;

   ch_state_e         state_q       [NUM_CHANNELS];
   ch_state_e         state_d       [NUM_CHANNELS];
   logic [ADDR_W-1:0] base_q        [NUM_CHANNELS];
   logic [ADDR_W-1:0] base_d        [NUM_CHANNELS];
   logic [SIZE_W-1:0] size_q        [NUM_CHANNELS];
   logic [SIZE_W-1:0] size_d        [NUM_CHANNELS];
   logic              shared_q      [NUM_CHANNELS];
   logic              shared_d      [NUM_CHANNELS];
   logic [SIZE_W-1:0] remaining_q   [NUM_CHANNELS];
   logic [SIZE_W-1:0] remaining_d   [NUM_CHANNELS];
   logic [SIZE_W-1:0] issued_q      [NUM_CHANNELS];
   logic [SIZE_W-1:0] issued_d      [NUM_CHANNELS];
   logic [OS_W-1:0]   outstanding_q [NUM_CHANNELS];
   logic [OS_W-1:0]   outstanding_d [NUM_CHANNELS];
   logic [SIZE_W-1:0] completed_q   [NUM_CHANNELS];
   logic [SIZE_W-1:0] completed_d   [NUM_CHANNELS];

   logic              enabled_q;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic              rsp_vld_q;
   logic [CH_W-1:0]   rsp_ch_q;
   logic [RS_W-1:0]   rsp_rs_q;

   logic              cmd_valid_q, cmd_valid_d;
   logic [CH_W-1:0]   cmd_channel_q, cmd_channel_d;
   logic [ADDR_W-1:0] cmd_address_q, cmd_address_d;
   logic [RS_W-1:0]   cmd_real_size_q, cmd_real_size_d;
   logic              cmd_shared_q, cmd_shared_d;
   logic [SIZE_W-1:0] job_counter_q, job_counter_d;
   logic              rsp_error_q, rsp_error_d;

   logic                    issue_gate;
   logic [NUM_CHANNELS-1:0] eligible;
   logic                    grant_vld;
   logic [CH_W-1:0]         grant_ch;
   logic [RS_W-1:0]         grant_rs;
   logic                    rsp_ok;

   // Elements carried by the next command: the tail of the job or a full line.
   function automatic logic [RS_W-1:0] clamp_real_size(input logic [SIZE_W-1:0] rem);
      if (rem >= SIZE_W'(ELEMS_PER_CL)) begin
         return RS_W'(ELEMS_PER_CL);
      end
      return rem[RS_W-1:0];
   endfunction

   // ---- stage 0: eligibility and round-robin grant ----
   always_comb begin
      issue_gate = enabled_q & ~cmd_alfull_in & ~data_alfull_in;
      eligible   = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         eligible[c] = issue_gate && (state_q[c] == ST_ISSUE) &&
                       (remaining_q[c] != '0) &&
                       (outstanding_q[c] < OS_W'(MAX_OUTSTANDING));
      end
   end

   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_ch  = '0;
      // Scan starting at the pointer so the most recently granted channel
      // is considered last.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
         if (!grant_vld && eligible[idx[CH_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_ch  = CH_W'(idx);
         end
      end
      grant_rs = clamp_real_size(remaining_q[grant_ch]);
      rr_ptr_d = rr_ptr_q;
      if (grant_vld) begin
         if (int'(grant_ch) == NUM_CHANNELS - 1) rr_ptr_d = '0;
         else                                    rr_ptr_d = grant_ch + 1'b1;
      end
   end

   // ---- stage 1: per-channel state, counters and latched responses ----
   always_comb begin
      logic cfg_hit, gnt_hit, rsp_hit;
      cfg_hit = 1'b0;
      gnt_hit = 1'b0;
      rsp_hit = 1'b0;
      rsp_ok  = 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         state_d[c]       = state_q[c];
         base_d[c]        = base_q[c];
         size_d[c]        = size_q[c];
         shared_d[c]      = shared_q[c];
         remaining_d[c]   = remaining_q[c];
         issued_d[c]      = issued_q[c];
         outstanding_d[c] = outstanding_q[c];
         completed_d[c]   = completed_q[c];

         cfg_hit = cfg_valid_in && (int'(cfg_channel_in) == c) &&
                   ((state_q[c] == ST_IDLE) || (state_q[c] == ST_DONE));
         gnt_hit = grant_vld && (int'(grant_ch) == c);
         // A response is only honoured if the channel has something pending.
         rsp_hit = rsp_vld_q && (int'(rsp_ch_q) == c) && (outstanding_q[c] != '0);
         if (rsp_hit) rsp_ok = 1'b1;

         if (cfg_hit) begin
            base_d[c]        = cfg_address_in;
            size_d[c]        = cfg_size_in;
            shared_d[c]      = cfg_shared_in;
            remaining_d[c]   = cfg_size_in;
            issued_d[c]      = '0;
            outstanding_d[c] = '0;
            completed_d[c]   = '0;
            state_d[c]       = (cfg_size_in == '0) ? ST_DONE : ST_ISSUE;
         end else begin
            if (gnt_hit) begin
               remaining_d[c] = remaining_q[c] - SIZE_W'(grant_rs);
               issued_d[c]    = issued_q[c] + 1'b1;
            end
            if (gnt_hit && !rsp_hit)      outstanding_d[c] = outstanding_q[c] + 1'b1;
            else if (!gnt_hit && rsp_hit) outstanding_d[c] = outstanding_q[c] - 1'b1;
            if (rsp_hit) completed_d[c] = completed_q[c] + SIZE_W'(rsp_rs_q);

            case (state_q[c])
               ST_ISSUE: if (gnt_hit && (remaining_q[c] == SIZE_W'(grant_rs)))
                            state_d[c] = ST_DRAIN;
               ST_DRAIN: if ((outstanding_q[c] == '0) && (completed_q[c] >= size_q[c]))
                            state_d[c] = ST_DONE;
               default:  ;
            endcase
         end
      end
   end

   always_comb begin
      job_counter_d = job_counter_q;
      rsp_error_d   = rsp_error_q;
      if (rsp_vld_q) begin
         if (rsp_ok) job_counter_d = job_counter_q + SIZE_W'(rsp_rs_q);
         else        rsp_error_d   = 1'b1;
      end
   end

   always_comb begin
      cmd_valid_d     = grant_vld;
      cmd_channel_d   = cmd_channel_q;
      cmd_address_d   = cmd_address_q;
      cmd_real_size_d = cmd_real_size_q;
      cmd_shared_d    = cmd_shared_q;
      if (grant_vld) begin
         cmd_channel_d   = grant_ch;
         cmd_address_d   = base_q[grant_ch] +
                           (ADDR_W'(issued_q[grant_ch]) * ADDR_W'(CL_BYTES));
         cmd_real_size_d = grant_rs;
         cmd_shared_d    = shared_q[grant_ch];
      end
   end

   always_comb begin
      cfg_ready_out    = 1'b0;
      channel_done_out = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         channel_done_out[c] = (state_q[c] == ST_DONE);
         if ((int'(cfg_channel_in) == c) &&
             ((state_q[c] == ST_IDLE) || (state_q[c] == ST_DONE)))
            cfg_ready_out = 1'b1;
      end
   end

   // ---- registers ----
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c]       <= ST_IDLE;
            base_q[c]        <= '0;
            size_q[c]        <= '0;
            shared_q[c]      <= 1'b0;
            remaining_q[c]   <= '0;
            issued_q[c]      <= '0;
            outstanding_q[c] <= '0;
            completed_q[c]   <= '0;
         end
         enabled_q       <= 1'b0;
         rr_ptr_q        <= '0;
         rsp_vld_q       <= 1'b0;
         rsp_ch_q        <= '0;
         rsp_rs_q        <= '0;
         cmd_valid_q     <= 1'b0;
         cmd_channel_q   <= '0;
         cmd_address_q   <= '0;
         cmd_real_size_q <= '0;
         cmd_shared_q    <= 1'b0;
         job_counter_q   <= '0;
         rsp_error_q     <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c]       <= state_d[c];
            base_q[c]        <= base_d[c];
            size_q[c]        <= size_d[c];
            shared_q[c]      <= shared_d[c];
            remaining_q[c]   <= remaining_d[c];
            issued_q[c]      <= issued_d[c];
            outstanding_q[c] <= outstanding_d[c];
            completed_q[c]   <= completed_d[c];
         end
         enabled_q       <= enabled_in;
         rr_ptr_q        <= rr_ptr_d;
         rsp_vld_q       <= rsp_valid_in;
         rsp_ch_q        <= rsp_channel_in;
         rsp_rs_q        <= rsp_real_size_in;
         cmd_valid_q     <= cmd_valid_d;
         cmd_channel_q   <= cmd_channel_d;
         cmd_address_q   <= cmd_address_d;
         cmd_real_size_q <= cmd_real_size_d;
         cmd_shared_q    <= cmd_shared_d;
         job_counter_q   <= job_counter_d;
         rsp_error_q     <= rsp_error_d;
      end
   end

   assign cmd_valid_out        = cmd_valid_q;
   assign cmd_channel_out      = cmd_channel_q;
   assign cmd_address_out      = cmd_address_q;
   assign cmd_real_size_out    = cmd_real_size_q;
   assign cmd_shared_out       = cmd_shared_q;
   assign job_counter_done_out = job_counter_q;
   assign rsp_error_out        = rsp_error_q;

endmodule

// File: tb/tb_cu_data_read_engine_multi_channel.sv
// ---------------------------------------------------------------------------
// Directed bench for cu_data_read_engine_multi_channel, built with a
// per-channel outstanding limit of 2 so that stalls are easy to provoke.
// ---------------------------------------------------------------------------
module tb_cu_data_read_engine_multi_channel;

   localparam int NC     = 4;
   localparam int CH_W   = 2;
   localparam int ADDR_W = 64;
   localparam int SIZE_W = 32;
   localparam int RS_W   = 6;

   logic              clock = 1'b0;
   logic              rstn;
   logic              enabled_in;
   logic              cfg_valid_in;
   logic [CH_W-1:0]   cfg_channel_in;
   logic [ADDR_W-1:0] cfg_address_in;
   logic [SIZE_W-1:0] cfg_size_in;
   logic              cfg_shared_in;
   logic              cfg_ready_out;
   logic              cmd_alfull_in;
   logic              data_alfull_in;
   logic              cmd_valid_out;
   logic [CH_W-1:0]   cmd_channel_out;
   logic [ADDR_W-1:0] cmd_address_out;
   logic [RS_W-1:0]   cmd_real_size_out;
   logic              cmd_shared_out;
   logic              rsp_valid_in;
   logic [CH_W-1:0]   rsp_channel_in;
   logic [RS_W-1:0]   rsp_real_size_in;
   logic [NC-1:0]     channel_done_out;
   logic [SIZE_W-1:0] job_counter_done_out;
   logic              rsp_error_out;

   cu_data_read_engine_multi_channel #(
      .NUM_CHANNELS   (NC),
      .ADDR_W         (ADDR_W),
      .SIZE_W         (SIZE_W),
      .ELEMS_PER_CL   (32),
      .CL_BYTES       (128),
      .MAX_OUTSTANDING(2)
   ) dut (
      .clock               (clock),
      .rstn                (rstn),
      .enabled_in          (enabled_in),
      .cfg_valid_in        (cfg_valid_in),
      .cfg_channel_in      (cfg_channel_in),
      .cfg_address_in      (cfg_address_in),
      .cfg_size_in         (cfg_size_in),
      .cfg_shared_in       (cfg_shared_in),
      .cfg_ready_out       (cfg_ready_out),
      .cmd_alfull_in       (cmd_alfull_in),
      .data_alfull_in      (data_alfull_in),
      .cmd_valid_out       (cmd_valid_out),
      .cmd_channel_out     (cmd_channel_out),
      .cmd_address_out     (cmd_address_out),
      .cmd_real_size_out   (cmd_real_size_out),
      .cmd_shared_out      (cmd_shared_out),
      .rsp_valid_in        (rsp_valid_in),
      .rsp_channel_in      (rsp_channel_in),
      .rsp_real_size_in    (rsp_real_size_in),
      .channel_done_out    (channel_done_out),
      .job_counter_done_out(job_counter_done_out),
      .rsp_error_out       (rsp_error_out)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [CH_W-1:0]   ch;
      logic [ADDR_W-1:0] addr;
      logic [RS_W-1:0]   rs;
      logic              sh;
   } cmd_t;

   cmd_t cq[$];
   int   total  = 0;
   int   bad    = 0;
   int   rd_idx = 0;
   int   n0     = 0;

   // Every command is visible for exactly one cycle; capture it mid-cycle.
   always @(negedge clock) begin
      if (rstn && cmd_valid_out)
         cq.push_back({cmd_channel_out, cmd_address_out, cmd_real_size_out, cmd_shared_out});
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [CH_W-1:0] ch, input logic [ADDR_W-1:0] a,
                      input logic [SIZE_W-1:0] s, input logic sh);
      cfg_valid_in   = 1'b1;
      cfg_channel_in = ch;
      cfg_address_in = a;
      cfg_size_in    = s;
      cfg_shared_in  = sh;
      tick();
      cfg_valid_in   = 1'b0;
   endtask

   task automatic rsp(input logic [CH_W-1:0] ch, input logic [RS_W-1:0] rs);
      rsp_valid_in     = 1'b1;
      rsp_channel_in   = ch;
      rsp_real_size_in = rs;
      tick();
      rsp_valid_in     = 1'b0;
   endtask

   task automatic chk_cmd(input string tag, input logic [CH_W-1:0] ch,
                          input logic [ADDR_W-1:0] a, input logic [RS_W-1:0] rs,
                          input logic sh);
      cmd_t c;
      c = '1;
      if (rd_idx < cq.size()) c = cq[rd_idx];
      rd_idx++;
      chk({tag, ".ch"},   64'(c.ch),   64'(ch));
      chk({tag, ".addr"}, c.addr,      a);
      chk({tag, ".rs"},   64'(c.rs),   64'(rs));
      chk({tag, ".sh"},   64'(c.sh),   64'(sh));
   endtask

   initial begin
      rstn             = 1'b0;
      enabled_in       = 1'b0;
      cfg_valid_in     = 1'b0;
      cfg_channel_in   = '0;
      cfg_address_in   = '0;
      cfg_size_in      = '0;
      cfg_shared_in    = 1'b0;
      cmd_alfull_in    = 1'b0;
      data_alfull_in   = 1'b0;
      rsp_valid_in     = 1'b0;
      rsp_channel_in   = '0;
      rsp_real_size_in = '0;
      repeat (2) tick();

      // reset state
      chk("rst.cmd_valid", cmd_valid_out, 0);
      chk("rst.cmd_channel", cmd_channel_out, 0);
      chk("rst.cmd_address", cmd_address_out, 0);
      chk("rst.cmd_rs", cmd_real_size_out, 0);
      chk("rst.cmd_shared", cmd_shared_out, 0);
      chk("rst.done", channel_done_out, 0);
      chk("rst.job", job_counter_done_out, 0);
      chk("rst.err", rsp_error_out, 0);

      rstn       = 1'b1;
      enabled_in = 1'b1;
      repeat (2) tick();

      // single channel, immediate responses: 70 elements -> 32,32,6
      rd_idx = cq.size();
      cfg(2'd0, 64'h1000, 32'd70, 1'b1);
      chk("t1.ready_busy", cfg_ready_out, 0);
      chk("t1.no_grant_at_cfg", cmd_valid_out, 0);
      for (int i = 0; i < 14; i++) begin
         tick();
         rsp_valid_in     = cmd_valid_out;
         rsp_channel_in   = cmd_channel_out;
         rsp_real_size_in = cmd_real_size_out;
      end
      rsp_valid_in = 1'b0;
      chk("t1.ncmd", 64'(cq.size() - rd_idx), 3);
      chk_cmd("t1.c0", 2'd0, 64'h1000, 6'd32, 1'b1);
      chk_cmd("t1.c1", 2'd0, 64'h1080, 6'd32, 1'b1);
      chk_cmd("t1.c2", 2'd0, 64'h1100, 6'd6,  1'b1);
      chk("t1.done", channel_done_out[0], 1);
      chk("t1.job", job_counter_done_out, 70);
      chk("t1.ready_done", cfg_ready_out, 1);

      // four channels, round-robin from pointer 0
      rstn       = 1'b0;
      enabled_in = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      rd_idx = cq.size();
      for (int c = 0; c < NC; c++) cfg(2'(c), 64'(c) << 16, 32'd64, c[0]);
      repeat (2) tick();
      chk("t2.stall_while_disabled", 64'(cq.size() - rd_idx), 0);
      enabled_in = 1'b1;
      repeat (10) tick();
      chk("t2.ncmd", 64'(cq.size() - rd_idx), 8);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < NC; c++)
            chk_cmd($sformatf("t2.r%0d.ch%0d", r, c), 2'(c),
                    (64'(c) << 16) + 64'(r * 128), 6'd32, c[0]);
      chk("t2.not_done_yet", channel_done_out, 0);
      for (int c = 0; c < NC; c++) begin
         rsp(2'(c), 6'd32);
         rsp(2'(c), 6'd32);
      end
      repeat (2) tick();
      chk("t2.all_done", channel_done_out, 4'hF);
      chk("t2.job", job_counter_done_out, 256);

      // outstanding limit with withheld responses
      rd_idx = cq.size();
      cfg(2'd1, 64'h4000, 32'd128, 1'b0);
      chk("t3.lat_k", cmd_valid_out, 0);
      tick();
      chk("t3.lat_k1", cmd_valid_out, 1);
      chk("t3.first_addr", cmd_address_out, 64'h4000);
      repeat (6) tick();
      chk("t3.stall_at_2", 64'(cq.size() - rd_idx), 2);
      rsp(2'd1, 6'd32);
      tick();
      chk("t3.no_early_grant", cmd_valid_out, 0);
      tick();
      chk("t3.one_more", cmd_valid_out, 1);
      chk("t3.one_more_addr", cmd_address_out, 64'h4100);
      repeat (5) tick();
      chk("t3.ncmd3", 64'(cq.size() - rd_idx), 3);
      chk("t3.not_done", channel_done_out[1], 0);
      rsp(2'd1, 6'd32);
      repeat (4) tick();
      chk("t3.ncmd4", 64'(cq.size() - rd_idx), 4);
      rsp(2'd1, 6'd32);
      rsp(2'd1, 6'd32);
      tick();
      chk("t3.done_r1", channel_done_out[1], 0);
      tick();
      chk("t3.done_r2", channel_done_out[1], 1);
      chk("t3.job", job_counter_done_out, 384);
      chk_cmd("t3.c0", 2'd1, 64'h4000, 6'd32, 1'b0);
      chk_cmd("t3.c1", 2'd1, 64'h4080, 6'd32, 1'b0);
      chk_cmd("t3.c2", 2'd1, 64'h4100, 6'd32, 1'b0);
      chk_cmd("t3.c3", 2'd1, 64'h4180, 6'd32, 1'b0);

      // command buffer almost full during issue
      rd_idx = cq.size();
      cfg(2'd2, 64'h8000, 32'd80, 1'b1);
      tick();
      chk("t4.first", cmd_valid_out, 1);
      cmd_alfull_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t4.blocked%0d", i), cmd_valid_out, 0);
      end
      cmd_alfull_in = 1'b0;
      tick();
      chk("t4.resume", cmd_valid_out, 1);
      chk("t4.resume_addr", cmd_address_out, 64'h8080);
      repeat (2) tick();
      chk("t4.ncmd2", 64'(cq.size() - rd_idx), 2);
      rsp(2'd2, 6'd32);
      rsp(2'd2, 6'd32);
      repeat (4) tick();
      rsp(2'd2, 6'd16);
      repeat (4) tick();
      chk("t4.ncmd3", 64'(cq.size() - rd_idx), 3);
      chk_cmd("t4.c0", 2'd2, 64'h8000, 6'd32, 1'b1);
      chk_cmd("t4.c1", 2'd2, 64'h8080, 6'd32, 1'b1);
      chk_cmd("t4.c2", 2'd2, 64'h8100, 6'd16, 1'b1);
      chk("t4.done", channel_done_out[2], 1);
      chk("t4.job", job_counter_done_out, 464);

      // spurious response to a channel with nothing pending
      chk("t5.err_clear", rsp_error_out, 0);
      rsp(2'd2, 6'd32);
      chk("t5.err_latched_only", rsp_error_out, 0);
      tick();
      chk("t5.err_set", rsp_error_out, 1);
      chk("t5.job_unchanged", job_counter_done_out, 464);
      repeat (3) tick();
      chk("t5.err_sticky", rsp_error_out, 1);

      // reset mid-job, then reload and size-0 job
      cfg(2'd0, 64'h1000, 32'd128, 1'b1);
      tick();
      chk("t6.pre_reset_cmd", cmd_valid_out, 1);
      rstn = 1'b0;
      #1;
      chk("t6.cmd_valid", cmd_valid_out, 0);
      chk("t6.cmd_channel", cmd_channel_out, 0);
      chk("t6.cmd_address", cmd_address_out, 0);
      chk("t6.cmd_rs", cmd_real_size_out, 0);
      chk("t6.cmd_shared", cmd_shared_out, 0);
      chk("t6.done", channel_done_out, 0);
      chk("t6.job", job_counter_done_out, 0);
      chk("t6.err", rsp_error_out, 0);
      tick();
      rstn = 1'b1;
      cfg(2'd0, 64'h1000, 32'd40, 1'b0);
      tick();
      chk("t6.reload_valid", cmd_valid_out, 1);
      chk("t6.reload_addr", cmd_address_out, 64'h1000);
      chk("t6.reload_rs", cmd_real_size_out, 32);
      tick();
      chk("t6.second_addr", cmd_address_out, 64'h1080);
      chk("t6.second_rs", cmd_real_size_out, 8);
      chk("t6.ch3_idle", channel_done_out[3], 0);
      cfg(2'd3, 64'h0, 32'd0, 1'b0);
      chk("t6.size0_done", channel_done_out[3], 1);
      chk("t6.ch0_busy", channel_done_out[0], 0);
      n0 = cq.size();
      repeat (4) tick();
      chk("t6.size0_no_cmd", 64'(cq.size() - n0), 0);
      chk("t6.err_after", rsp_error_out, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
